// File: rtl/err_monitor.sv
// PCIe error monitor: synchronises and normalises raw error levels, then keeps
// per-channel pulses, sticky flags, saturating counters and a first-error capture.

module err_chan #(
   parameter int   SYNC_STAGES = 2,
   parameter int   CNT_WIDTH   = 16,
   parameter logic ACTIVE_LOW  = 1'b0
) (
   input  logic                 trn_clk,
   input  logic                 reset_n,
   input  logic                 raw,
   input  logic                 mask,
   input  logic                 clr,
   output logic                 lvl,
   output logic                 evt,
   output logic                 pulse,
   output logic                 sticky,
   output logic [CNT_WIDTH-1:0] cnt
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   lvl_d;

   assign lvl = sync[SYNC_STAGES-1] ^ ACTIVE_LOW;
   // lvl_d follows the level even while masked, so unmasking a high level is silent
   assign evt = lvl & ~lvl_d & mask;

   always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync   <= {SYNC_STAGES{ACTIVE_LOW}};
         lvl_d  <= 1'b0;
         pulse  <= 1'b0;
         sticky <= 1'b0;
         cnt    <= '0;
      end else begin
         sync[0] <= raw;
         for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
         lvl_d  <= lvl;
         pulse  <= evt;
         sticky <= evt | (sticky & ~clr);
         // clear first, then the event counts on top of it
         if (clr)
            cnt <= evt ? CNT_WIDTH'(1) : '0;
         else if (evt && (cnt != '1))
            cnt <= cnt + CNT_WIDTH'(1);
      end
   end

endmodule

module err_monitor #(
   parameter int                 NUM_ERR        = 5,
   parameter int                 SYNC_STAGES    = 2,
   parameter int                 CNT_WIDTH      = 16,
   parameter logic [NUM_ERR-1:0] ERR_ACTIVE_LOW = 5'b10000,
   parameter int                 IDX_W          = 3
) (
   input  logic                 trn_clk,
   input  logic                 reset_n,
   input  logic [NUM_ERR-1:0]   err_raw,
   input  logic [NUM_ERR-1:0]   err_mask,
   input  logic                 clr_valid,
   input  logic [NUM_ERR-1:0]   clr_sel,
   input  logic [IDX_W-1:0]     cnt_sel,
   output logic [CNT_WIDTH-1:0] cnt_rd_data,
   output logic [NUM_ERR-1:0]   detected_errors,
   output logic [NUM_ERR-1:0]   err_pulse,
   output logic [NUM_ERR-1:0]   err_sticky,
   output logic                 first_err_valid,
   output logic [IDX_W-1:0]     first_err_idx,
   output logic                 irq
);

   typedef enum logic {IDLE, CAPTURED} fe_state_t;

   logic [NUM_ERR-1:0]                evt;
   logic [NUM_ERR-1:0][CNT_WIDTH-1:0] cnt;
   logic [IDX_W-1:0]                  lo_idx;
   logic                              clr_hit;
   logic [CNT_WIDTH-1:0]              rd_mux;
   fe_state_t                         fe_state;

   for (genvar g = 0; g < NUM_ERR; g++) begin : g_chan
      err_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_WIDTH   (CNT_WIDTH),
         .ACTIVE_LOW  (ERR_ACTIVE_LOW[g])
      ) u_chan (
         .trn_clk (trn_clk),
         .reset_n (reset_n),
         .raw     (err_raw[g]),
         .mask    (err_mask[g]),
         .clr     (clr_valid & clr_sel[g]),
         .lvl     (detected_errors[g]),
         .evt     (evt[g]),
         .pulse   (err_pulse[g]),
         .sticky  (err_sticky[g]),
         .cnt     (cnt[g])
      );
   end

   assign irq             = |err_sticky;
   assign first_err_valid = (fe_state == CAPTURED);

   always_comb begin
      lo_idx  = '0;
      clr_hit = 1'b0;
      rd_mux  = '0;
      for (int i = NUM_ERR-1; i >= 0; i--) begin
         if (evt[i]) lo_idx = IDX_W'(i);
      end
      for (int i = 0; i < NUM_ERR; i++) begin
         if (clr_sel[i] && (32'(first_err_idx) == i)) clr_hit = clr_valid;
         // out-of-range selects match nothing and read as zero
         if (32'(cnt_sel) == i) rd_mux = cnt[i];
      end
   end

   always_ff @(posedge trn_clk or negedge reset_n) begin
      if (!reset_n) begin
         fe_state      <= IDLE;
         first_err_idx <= '0;
         cnt_rd_data   <= '0;
      end else begin
         cnt_rd_data <= rd_mux;
         case (fe_state)
            IDLE: begin
               if (|evt) begin
                  fe_state      <= CAPTURED;
                  first_err_idx <= lo_idx;
               end
            end
            CAPTURED: begin
               if (clr_hit) begin
                  if (|evt) first_err_idx <= lo_idx;
                  else      fe_state      <= IDLE;
               end
            end
            default: fe_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_err_monitor.sv
// Scoreboard bench for err_monitor: expected pulses and counter reads are queued
// by the stimulus and popped by an independent monitor.

module tb_err_monitor;

   localparam int NE = 5;
   localparam int CW = 4;
   localparam int IW = 3;

   logic          trn_clk = 1'b0;
   logic          reset_n;
   logic [NE-1:0] err_raw, err_mask, clr_sel;
   logic          clr_valid;
   logic [IW-1:0] cnt_sel;
   logic [CW-1:0] cnt_rd_data;
   logic [NE-1:0] detected_errors, err_pulse, err_sticky;
   logic          first_err_valid, irq;
   logic [IW-1:0] first_err_idx;

   logic          rd_en = 1'b0, rd_pend = 1'b0;
   logic [NE-1:0] pulse_q[$];
   logic [CW-1:0] rd_q[$];
   int            checks = 0, failures = 0;

   err_monitor #(
      .NUM_ERR(NE), .SYNC_STAGES(2), .CNT_WIDTH(CW),
      .ERR_ACTIVE_LOW(5'b10000), .IDX_W(IW)
   ) dut (
      .trn_clk(trn_clk), .reset_n(reset_n), .err_raw(err_raw), .err_mask(err_mask),
      .clr_valid(clr_valid), .clr_sel(clr_sel), .cnt_sel(cnt_sel),
      .cnt_rd_data(cnt_rd_data), .detected_errors(detected_errors),
      .err_pulse(err_pulse), .err_sticky(err_sticky),
      .first_err_valid(first_err_valid), .first_err_idx(first_err_idx), .irq(irq)
   );

   always #5 trn_clk = ~trn_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge trn_clk);
      #1;
   endtask

   task automatic rd(input int ch, input logic [CW-1:0] exp);
      cnt_sel = IW'(ch);
      rd_en   = 1'b1;
      rd_q.push_back(exp);
      tick();
      rd_en   = 1'b0;
   endtask

   // monitor: any nonzero pulse and any completed read is matched to the queues
   always @(posedge trn_clk) rd_pend <= rd_en;

   always @(negedge trn_clk) begin
      if (err_pulse != '0) begin
         if (pulse_q.size() == 0) chk("unexpected_pulse", 32'(err_pulse), 32'h0);
         else chk("err_pulse", 32'(err_pulse), 32'(pulse_q.pop_front()));
      end
      if (rd_pend) begin
         if (rd_q.size() == 0) chk("unexpected_read", 32'(cnt_rd_data), 32'h0);
         else chk("cnt_rd_data", 32'(cnt_rd_data), 32'(rd_q.pop_front()));
      end
   end

   initial begin
      // 1: reset with inactive raw levels
      reset_n = 1'b0; err_raw = 5'b10000; err_mask = 5'b11111;
      clr_valid = 1'b0; clr_sel = '0; cnt_sel = '0;
      tick(3);
      chk("rst_detected", 32'(detected_errors), 32'h0);
      chk("rst_sticky",   32'(err_sticky), 32'h0);
      chk("rst_irq",      32'(irq), 32'h0);
      chk("rst_first",    32'(first_err_valid), 32'h0);
      chk("rst_rd",       32'(cnt_rd_data), 32'h0);
      reset_n = 1'b1;
      tick(4);
      chk("post_rst_detected", 32'(detected_errors), 32'h0);
      for (int i = 0; i < NE; i++) rd(i, 4'd0);
      rd(7, 4'd0);

      // 2: single rising edge on ch2, held 10 cycles
      err_raw = 5'b10100;
      tick();
      chk("t2_det_lat1", 32'(detected_errors), 32'h0);
      pulse_q.push_back(5'b00100);
      tick();
      chk("t2_det_lat2", 32'(detected_errors), 32'b00100);
      tick();
      chk("t2_sticky", 32'(err_sticky), 32'b00100);
      chk("t2_first_v", 32'(first_err_valid), 32'h1);
      chk("t2_first_idx", 32'(first_err_idx), 32'd2);
      chk("t2_irq", 32'(irq), 32'h1);
      tick(7);
      err_raw = 5'b10000;
      tick(4);
      rd(2, 4'd1);

      // 3: active-low ch4 pulsed 20 times, counter saturates at 15
      for (int n = 0; n < 20; n++) begin
         pulse_q.push_back(5'b10000);
         err_raw = 5'b00000; tick(2);
         err_raw = 5'b10000; tick(2);
      end
      tick(4);
      rd(4, 4'd15);
      rd(6, 4'd0);
      chk("t3_sticky", 32'(err_sticky), 32'b10100);
      chk("t3_first_idx", 32'(first_err_idx), 32'd2);

      // 4: clear to IDLE, then simultaneous edges on ch3 and ch1
      clr_valid = 1'b1; clr_sel = 5'b10100; tick();
      clr_valid = 1'b0; clr_sel = '0;
      chk("t4_clr_sticky", 32'(err_sticky), 32'h0);
      chk("t4_clr_first", 32'(first_err_valid), 32'h0);
      rd(4, 4'd0);
      err_raw = 5'b11010;
      pulse_q.push_back(5'b01010);
      tick(4);
      chk("t4_first_v", 32'(first_err_valid), 32'h1);
      chk("t4_first_idx", 32'(first_err_idx), 32'd1);
      clr_valid = 1'b1; clr_sel = 5'b00010; tick();
      clr_valid = 1'b0; clr_sel = '0;
      chk("t4_first_clr", 32'(first_err_valid), 32'h0);
      chk("t4_sticky3", 32'(err_sticky), 32'b01000);
      err_raw = 5'b10000;
      tick(4);

      // 5: clear of ch2 in the same cycle as its edge; read sees pre-update value
      err_raw = 5'b10100;
      tick(2);
      pulse_q.push_back(5'b00100);
      clr_valid = 1'b1; clr_sel = 5'b00100;
      rd(2, 4'd0);
      clr_valid = 1'b0; clr_sel = '0;
      chk("t5_sticky", 32'(err_sticky), 32'b01100);
      chk("t5_first_idx", 32'(first_err_idx), 32'd2);
      rd(2, 4'd1);
      err_raw = 5'b10000;
      tick(4);

      // 6: masking on ch0
      err_mask = 5'b11110;
      err_raw  = 5'b10001;
      tick(4);
      chk("t6_det_masked", 32'(detected_errors), 32'b00001);
      chk("t6_sticky_masked", 32'(err_sticky), 32'b01100);
      err_mask = 5'b11111;
      tick(3);
      rd(0, 4'd0);
      err_raw = 5'b10000; tick(3);
      err_raw = 5'b10001;
      pulse_q.push_back(5'b00001);
      tick(4);
      rd(0, 4'd1);
      err_mask = 5'b00000;
      tick(2);
      chk("t6_mask_keeps", 32'(err_sticky), 32'b01101);
      err_mask = 5'b11111;
      err_raw  = 5'b10000;
      tick(1);
      #3 reset_n = 1'b0;
      #1;
      chk("t6_arst_sticky", 32'(err_sticky), 32'h0);
      chk("t6_arst_irq",    32'(irq), 32'h0);
      chk("t6_arst_first",  32'(first_err_valid), 32'h0);
      chk("t6_arst_det",    32'(detected_errors), 32'h0);
      tick(2);
      reset_n = 1'b1;
      tick(4);
      rd(0, 4'd0);
      rd(2, 4'd0);
      tick(3);

      chk("pulse_q_drained", 32'(pulse_q.size()), 32'h0);
      chk("rd_q_drained",    32'(rd_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
